// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: block RAM below the top 16 words, game I/O above.
// Loads return one cycle later and always see the contents from before the clock edge.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned NUM_MOLES   = 9,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address_dmem,
   input  logic [31:0]           d_dmem,
   input  logic                  wren,
   input  logic                  ren,
   output logic [31:0]           q_dmem,
   input  logic [NUM_MOLES-1:0]  buttons,
   output logic [NUM_MOLES-1:0]  leds,
   output logic                  timeout
);

   localparam int unsigned RamWords = (1 << ADDR_WIDTH) - 16;

   logic [31:0]          ram [RamWords];
   logic                 is_mmio;
   logic [3:0]           reg_sel;
   logic                 wr_led, wr_cyc, wr_cnt, rd_clr;
   logic [NUM_MOLES-1:0] edge_det;
   logic [31:0]          mmio_rd;

   logic [NUM_MOLES-1:0] sync_q [SYNC_STAGES];
   logic [NUM_MOLES-1:0] prev_q;
   logic [SYNC_STAGES:0] settle_q, settle_d;
   logic [NUM_MOLES-1:0] led_q, led_d;
   logic [NUM_MOLES-1:0] evt_q, evt_d;
   logic [31:0]          cyc_q, cyc_d;
   logic [31:0]          cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
   logic [31:0]          rd_q, rd_d;

   assign is_mmio = &address_dmem[ADDR_WIDTH-1:4];
   assign reg_sel = address_dmem[3:0];

   always_ff @(posedge clock) begin
      if (!reset && wren && !is_mmio) begin
         ram[address_dmem] <= d_dmem;
      end
   end

   always_comb begin
      wr_led = wren && is_mmio && (reg_sel == 4'd0);
      wr_cyc = wren && is_mmio && (reg_sel == 4'd2);
      wr_cnt = wren && is_mmio && (reg_sel == 4'd3);
      rd_clr = ren && !wren && is_mmio && (reg_sel == 4'd1);

      // Edges are ignored until the synchroniser has refilled after reset, so a held
      // button is absorbed into prev_q rather than reported as a press.
      edge_det = settle_q[SYNC_STAGES] ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;
      settle_d = {settle_q[SYNC_STAGES-1:0], 1'b1};

      led_d = wr_led ? d_dmem[NUM_MOLES-1:0] : led_q;
      // A new edge is ORed in after the clear so it is never lost.
      evt_d = (rd_clr ? '0 : evt_q) | edge_det;
      cyc_d = wr_cyc ? d_dmem : cyc_q + 32'd1;
      if (wr_cnt) begin
         cnt_d = d_dmem;
      end else if (cnt_q != 32'd0) begin
         cnt_d = cnt_q - 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
      timeout_d = !wr_cnt && (cnt_q == 32'd1);

      case (reg_sel)
         4'd0:    mmio_rd = {{(32 - NUM_MOLES){1'b0}}, led_q};
         4'd1:    mmio_rd = {{(32 - NUM_MOLES){1'b0}}, evt_q};
         4'd2:    mmio_rd = cyc_q;
         4'd3:    mmio_rd = cnt_q;
         default: mmio_rd = 32'd0;
      endcase
      rd_d = is_mmio ? mmio_rd : ram[address_dmem];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= buttons;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q    <= '0;
         settle_q  <= '0;
         led_q     <= '0;
         evt_q     <= '0;
         cyc_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         rd_q      <= '0;
      end else begin
         prev_q    <= sync_q[SYNC_STAGES-1];
         settle_q  <= settle_d;
         led_q     <= led_d;
         evt_q     <= evt_d;
         cyc_q     <= cyc_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         rd_q      <= rd_d;
      end
   end

   assign q_dmem  = rd_q;
   assign leds    = led_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, LED, button events, cycle counter, countdown, reset.
module tb_dmem_responder;

   logic        clock;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] d_dmem;
   logic        wren;
   logic        ren;
   logic [31:0] q_dmem;
   logic [8:0]  buttons;
   logic [8:0]  leds;
   logic        timeout;

   int n_total = 0;
   int n_bad   = 0;
   int pulses;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .d_dmem       (d_dmem),
      .wren         (wren),
      .ren          (ren),
      .q_dmem       (q_dmem),
      .buttons      (buttons),
      .leds         (leds),
      .timeout      (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present one bus cycle, then land 1 time unit after the edge that consumed it.
   task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
      address_dmem = a;
      d_dmem       = d;
      wren         = w;
      ren          = r;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      buttons = '0;
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      check("rst_q", q_dmem, 32'd0);
      check("rst_leds", {23'd0, leds}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      reset = 1'b0;

      // RAM write, read, read-old on same-address write
      cyc(12'h010, 32'h1234_5678, 1'b1, 1'b0);
      cyc(12'h010, 32'd0, 1'b0, 1'b1);
      check("ram_rd", q_dmem, 32'h1234_5678);
      cyc(12'h010, 32'hAAAA_5555, 1'b1, 1'b0);
      check("ram_rd_old", q_dmem, 32'h1234_5678);
      cyc(12'h010, 32'd0, 1'b0, 1'b1);
      check("ram_rd_new", q_dmem, 32'hAAAA_5555);
      cyc(12'hFEF, 32'hCAFE_F00D, 1'b1, 1'b0);
      cyc(12'hFEF, 32'd0, 1'b0, 1'b1);
      check("ram_top", q_dmem, 32'hCAFE_F00D);

      // LED register keeps only the low 9 bits
      cyc(12'hFF0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check("leds_set", {23'd0, leds}, 32'h0000_01FF);
      cyc(12'hFF0, 32'd0, 1'b0, 1'b1);
      check("led_rd", q_dmem, 32'h0000_01FF);

      // Countdown from 5 with a single timeout pulse
      cyc(12'hFF3, 32'd5, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(12'hFF3, 32'd0, 1'b0, 1'b1);
         check($sformatf("cnt_rd%0d", i), q_dmem, 32'(5 - i));
         check($sformatf("cnt_to%0d", i), {31'd0, timeout}, (i == 4) ? 32'd1 : 32'd0);
      end
      cyc(12'hFF3, 32'd0, 1'b0, 1'b1);
      check("cnt_hold", q_dmem, 32'd0);
      check("cnt_hold_to", {31'd0, timeout}, 32'd0);
      // Writing 0 while at 1 must not pulse
      cyc(12'hFF3, 32'd2, 1'b1, 1'b0);
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      cyc(12'hFF3, 32'd0, 1'b1, 1'b0);
      check("wr0_no_to", {31'd0, timeout}, 32'd0);
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      check("wr0_no_to2", {31'd0, timeout}, 32'd0);

      // Button 3 press: event visible after the synchroniser + edge detect
      buttons = 9'h008;
      for (int i = 0; i < 4; i++) begin
         cyc(12'hFF1, 32'd0, 1'b0, 1'b0);
         if (i == 2) check("btn_early", q_dmem, 32'd0);
      end
      check("btn_evt", q_dmem, 32'h8);
      cyc(12'hFF1, 32'd0, 1'b0, 1'b1);
      check("btn_clr_rd", q_dmem, 32'h8);
      cyc(12'hFF1, 32'd0, 1'b0, 1'b1);
      check("btn_cleared", q_dmem, 32'd0);
      for (int i = 0; i < 4; i++) cyc(12'hFF1, 32'd0, 1'b0, 1'b0);
      check("btn_held", q_dmem, 32'd0);

      // Button 5 edge coincides with a clearing load
      buttons = 9'h000;
      for (int i = 0; i < 4; i++) cyc(12'h000, 32'd0, 1'b0, 1'b0);
      buttons = 9'h020;
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      cyc(12'hFF1, 32'd0, 1'b0, 1'b1);
      check("btn_coinc_rd", q_dmem, 32'd0);
      cyc(12'hFF1, 32'd0, 1'b0, 1'b0);
      check("btn_coinc_kept", q_dmem, 32'h20);

      // Cycle counter load and wrap
      cyc(12'hFF2, 32'hFFFF_FFFE, 1'b1, 1'b0);
      cyc(12'hFF2, 32'd0, 1'b0, 1'b1);
      check("cyc_fe", q_dmem, 32'hFFFF_FFFE);
      cyc(12'hFF2, 32'd0, 1'b0, 1'b1);
      check("cyc_ff", q_dmem, 32'hFFFF_FFFF);
      cyc(12'hFF2, 32'd0, 1'b0, 1'b1);
      check("cyc_wrap", q_dmem, 32'd0);

      // Unused MMIO slot
      cyc(12'hFF5, 32'h0000_0123, 1'b1, 1'b0);
      cyc(12'hFF5, 32'd0, 1'b0, 1'b1);
      check("mmio_unused", q_dmem, 32'd0);

      // Reset mid-countdown (COUNTDN=3) with a RAM write attempted during reset
      cyc(12'hFF3, 32'd5, 1'b1, 1'b0);
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      cyc(12'h000, 32'd0, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(12'h010, 32'hDEAD_BEEF, 1'b1, 1'b0);
      check("mid_rst_q", q_dmem, 32'd0);
      check("mid_rst_leds", {23'd0, leds}, 32'd0);
      check("mid_rst_to", {31'd0, timeout}, 32'd0);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(12'h000, 32'd0, 1'b0, 1'b0);
         if (timeout) pulses++;
      end
      check("rst_no_pulse", 32'(pulses), 32'd0);
      cyc(12'hFF1, 32'd0, 1'b0, 1'b0);
      check("rst_held_btn", q_dmem, 32'd0);
      cyc(12'hFF3, 32'd0, 1'b0, 1'b1);
      check("rst_cnt", q_dmem, 32'd0);
      cyc(12'h010, 32'd0, 1'b0, 1'b1);
      check("ram_retained", q_dmem, 32'hAAAA_5555);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
